// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types, constants and helpers for the SIPO deserializer
//
// Purpose: deserializer FSM state type, default word width and the even-parity helper.
// Ports:   none (package).
// Config:  the PARITY state is only entered when PARITY_EN is defined.

package deser_pkg;

    typedef enum logic {
        SHIFT  = 1'b0,
        PARITY = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Even parity: 1 when the word holds an odd number of ones, so the
    // word plus its parity bit always carries an even count.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - serial input and word handshake bundle of the deserializer
//
// Purpose: groups the serial input and the parallel valid/ready output.
// Ports:   sin, sin_valid   serial bit and its qualifier
//          out_data         completed word
//          out_valid        word available
//          out_ready        consumer accepts the word
// Modports: master = deserializer side, slave = link/consumer side.

interface sipo_deser_if import deser_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  sin,
        input  sin_valid,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output sin,
        output sin_valid,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/hold_reg.sv
// rtl/hold_reg.sv - one-entry valid/ready holding register
//
// Purpose: holds one word until the consumer takes it; can drain and refill on one edge.
// Ports:   clk, rst         clock, synchronous active-high reset
//          load, load_data  offer a new word this edge
//          ready            consumer accepts the held word this edge
//          data, valid      held word and full flag
//          drop             offered word cannot be taken (register full and not draining)

module hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             drop
);

    logic free;

    // A full register still counts as free when it is being drained on this edge.
    assign free = ~valid | ready;
    assign drop = load & ~free;

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load && free) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer, MSB first
//
// Purpose: collects WIDTH qualified serial bits MSB first and hands each word
//          to a one-entry holding register with a valid/ready handshake.
// Ports:   clk, rst     clock, synchronous active-high reset
//          bus          serial input and word output handshake (master modport)
//          overrun      sticky, a completed word was dropped
//          bit_cnt      bits collected in the current word
//          parity_err   one-cycle pulse on an even-parity failure (PARITY_EN only)
// Config:  PARITY_EN - a trailing even-parity bit follows each word; the word
//          is delivered on the parity edge.

module sipo_deser import deser_pkg::*; #(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sipo_deser_if.master     bus,
    output logic             overrun,
`ifdef PARITY_EN
    output logic             parity_err,
`endif
    output logic [CNT_W-1:0] bit_cnt
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] load_data;
    logic             last_bit;
    logic             load;
    logic             drop;

    assign next_word = {shreg[WIDTH-2:0], bus.sin};
    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));

`ifdef PARITY_EN
    // The shift register already holds the full word while waiting for parity.
    assign load      = bus.sin_valid && (state == PARITY);
    assign load_data = shreg;
`else
    assign load      = bus.sin_valid && (state == SHIFT) && last_bit;
    assign load_data = next_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= overrun | drop;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
            if (bus.sin_valid) begin
                case (state)
                    SHIFT: begin
                        shreg <= next_word;
                        if (last_bit) begin
                            bit_cnt <= '0;
`ifdef PARITY_EN
                            state   <= PARITY;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        parity_err <= even_parity(32'(shreg)) ^ bus.sin;
                        state      <= SHIFT;
                    end
`endif
                    default: state <= SHIFT;
                endcase
            end
        end
    end

    hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .ready     (bus.out_ready),
        .data      (bus.out_data),
        .valid     (bus.out_valid),
        .drop      (drop)
    );

endmodule
